// File: rtl/rpn_stack_calculator.sv
// RPN calculator core: signed decimal entry, DEPTH-word operand stack and a
// sequenced add/sub/mul datapath with sticky overflow and stack-error flags.
module rpn_stack_calculator #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       key_valid,
  input  logic [4:0]                 key_code,
  output logic [WIDTH-1:0]           disp,
  output logic                       sign,
  output logic                       o_flag,
  output logic                       err,
  output logic                       busy,
  output logic                       key_drop,
  output logic [$clog2(DEPTH+1)-1:0] depth
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);
  localparam int EW = WIDTH + 5;
  localparam int PW = 2 * WIDTH;
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [4:0] K_ENTER = 5'd10;
  localparam logic [4:0] K_NEG   = 5'd11;
  localparam logic [4:0] K_ADD   = 5'd12;
  localparam logic [4:0] K_SUB   = 5'd13;
  localparam logic [4:0] K_CLEAR = 5'd15;

  typedef enum logic [2:0] {IDLE, LOAD_B, LOAD_A, EXEC, PUSH} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

  state_t                  state, state_n;
  op_t                     op, op_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic                    active, active_n, of_n, err_n, busy_n, drop_n;
  logic signed [WIDTH-1:0] ent, ent_n, op_a, op_b, res, top, b_val, wr_val;
  logic signed [WIDTH-1:0] stk [DEPTH];
  logic                    ent_we, wr_en, ld_a, ld_b, ld_r;
  logic [IW-1:0]           idx_top, idx_push, wr_idx;
  logic signed [EW-1:0]    ent_x, dig_x, ent_dec;
  logic [WIDTH:0]          alu_out;

  function automatic logic fits(input logic signed [EW-1:0] v);
    return (v >= EW'(SMIN)) && (v <= EW'(SMAX));
  endfunction

  // Returns {overflow, wrapped result}; overflow means the exact value is not representable.
  function automatic logic [WIDTH:0] alu(input op_t f, input logic signed [WIDTH-1:0] a,
                                         input logic signed [WIDTH-1:0] b);
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] lo;
    case (f)
      OP_ADD:  p = PW'(a) + PW'(b);
      OP_SUB:  p = PW'(a) - PW'(b);
      default: p = PW'(a) * PW'(b);
    endcase
    lo = PW'(signed'(p[WIDTH-1:0]));
    return {p != lo, p[WIDTH-1:0]};
  endfunction

  assign idx_top  = IW'(cnt - CW'(1));
  assign idx_push = IW'(cnt);
  assign top      = (cnt != '0) ? stk[idx_top] : '0;
  assign ent_x    = EW'(ent);
  assign dig_x    = EW'(key_code[3:0]);
  assign ent_dec  = ent[WIDTH-1] ? ent_x * EW'(10) - dig_x : ent_x * EW'(10) + dig_x;
  assign alu_out  = alu(op, op_a, op_b);
  assign disp     = active ? ent : top;
  assign sign     = disp[WIDTH-1];
  assign depth    = cnt;

  always_comb begin
    state_n  = state;
    op_n     = op;
    cnt_n    = cnt;
    active_n = active;
    of_n     = o_flag;
    err_n    = err;
    busy_n   = busy;
    drop_n   = 1'b0;
    ent_we   = 1'b0;
    ent_n    = ent;
    wr_en    = 1'b0;
    wr_idx   = idx_push;
    wr_val   = res;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    ld_r     = 1'b0;
    b_val    = top;
    if (key_valid && key_code == K_CLEAR) begin
      state_n  = IDLE;
      cnt_n    = '0;
      active_n = 1'b0;
      of_n     = 1'b0;
      err_n    = 1'b0;
      busy_n   = 1'b0;
      ent_we   = 1'b1;
      ent_n    = '0;
    end else if (state != IDLE) begin
      drop_n = key_valid && (key_code < K_CLEAR);
      case (state)
        LOAD_B: begin ld_b = 1'b1; cnt_n = cnt - CW'(1); state_n = LOAD_A; end
        LOAD_A: begin ld_a = 1'b1; cnt_n = cnt - CW'(1); state_n = EXEC; end
        EXEC:   begin ld_r = 1'b1; of_n = o_flag | alu_out[WIDTH]; state_n = PUSH; end
        PUSH:   begin
          wr_en   = 1'b1;
          cnt_n   = cnt + CW'(1);
          state_n = IDLE;
          busy_n  = 1'b0;
        end
        default: begin state_n = IDLE; busy_n = 1'b0; end
      endcase
    end else if (key_valid && key_code < K_CLEAR) begin
      // Flags describe only the most recently accepted key.
      of_n  = 1'b0;
      err_n = 1'b0;
      if (key_code < K_ENTER) begin
        if (!active) begin
          ent_we   = 1'b1;
          ent_n    = WIDTH'(key_code[3:0]);
          active_n = 1'b1;
        end else if (fits(ent_dec)) begin
          ent_we = 1'b1;
          ent_n  = ent_dec[WIDTH-1:0];
        end else begin
          of_n = 1'b1;
        end
      end else if (key_code == K_NEG) begin
        if (active) begin
          if (ent == SMIN) of_n = 1'b1;
          else begin ent_we = 1'b1; ent_n = -ent; end
        end else if (cnt == '0) begin
          err_n = 1'b1;
        end else if (top == SMIN) begin
          of_n = 1'b1;
        end else begin
          wr_en  = 1'b1;
          wr_idx = idx_top;
          wr_val = -top;
        end
      end else if (key_code == K_ENTER) begin
        if (cnt == FULL || (!active && cnt == '0)) begin
          err_n = 1'b1;
        end else begin
          wr_en    = 1'b1;
          wr_val   = active ? ent : top;
          cnt_n    = cnt + CW'(1);
          active_n = 1'b0;
        end
      end else begin
        op_n = (key_code == K_ADD) ? OP_ADD : (key_code == K_SUB) ? OP_SUB : OP_MUL;
        // An active entry is the B operand, so the first pop is skipped.
        if (active && cnt != '0) begin
          ld_b     = 1'b1;
          b_val    = ent;
          active_n = 1'b0;
          state_n  = LOAD_A;
          busy_n   = 1'b1;
        end else if (!active && cnt >= CW'(2)) begin
          state_n = LOAD_B;
          busy_n  = 1'b1;
        end else begin
          err_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      op       <= OP_ADD;
      cnt      <= '0;
      active   <= 1'b0;
      o_flag   <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      key_drop <= 1'b0;
    end else begin
      state    <= state_n;
      op       <= op_n;
      cnt      <= cnt_n;
      active   <= active_n;
      o_flag   <= of_n;
      err      <= err_n;
      busy     <= busy_n;
      key_drop <= drop_n;
    end
  end

  always_ff @(posedge clk) begin
    if (ent_we) ent <= ent_n;
    if (wr_en) stk[wr_idx] <= wr_val;
    if (ld_a) op_a <= top;
    if (ld_b) op_b <= b_val;
    if (ld_r) res <= alu_out[WIDTH-1:0];
  end
endmodule
